myooo_missu_sched: RTL

//  Scheduler for the L1D miss unit: allocates MISSU entries for LSU line misses and issues one L2

---
 rtl/myooo_missu_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/myooo_missu_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// myooo_missu_sched
// Scheduler for the L1D miss unit. It allocates a miss entry for each new LSU
// line miss and sends one L2 refill request per entry, picking among pending
// entries round-robin. It buffers each returned line and sends the DCACHE fill
// writes, also round-robin.
//
// Entry lifecycle: FREE -> REQ -> WAIT -> FILL -> FREE. Each state change
// takes effect on the cycle after the event that causes it.
//
// Ports
//   i_clk, i_reset                      clock, asynchronous active-high reset
//   i_miss_valid/i_miss_paddr           LSU miss request
//   o_miss_ready/o_miss_id              accept (combinational) and entry id
//   o_l2_req_valid/paddr/tag            L2 refill request (line-aligned paddr)
//   i_l2_req_ready                      L2 accepts the request
//   i_l2_resp_valid/tag/data            L2 refill return (always accepted)
//   o_fill_valid/paddr/data             DCACHE fill write
//   i_fill_ready                        DCACHE accepts the fill
//   o_busy_vec                          per-entry "not FREE"
//   o_spurious_resp                     pulse, one cycle after a response
//                                       whose tag is not waiting for data
//
// Configuration macro: MYOOO_MISSU_MERGE_EN
//   Defined: a miss to a line that is already in flight is accepted and
//   reports that entry's id. No new entry is allocated and no new L2 request
//   is sent. A merge is possible even when no entry is FREE.
//   Undefined: a miss to a line that is already in flight is stalled until
//   that entry returns to FREE.
// -----------------------------------------------------------------------------
module myooo_missu_sched #(
    parameter int ENTRY_SIZE    = 2,
    parameter int PADDR_W       = 56,
    parameter int LINE_OFFSET_W = 6,
    parameter int LINE_W        = 512,
    localparam int ENTRY_W      = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_miss_valid,
    input  logic [PADDR_W-1:0]    i_miss_paddr,
    output logic                  o_miss_ready,
    output logic [ENTRY_W-1:0]    o_miss_id,
    output logic                  o_l2_req_valid,
    output logic [PADDR_W-1:0]    o_l2_req_paddr,
    output logic [ENTRY_W-1:0]    o_l2_req_tag,
    input  logic                  i_l2_req_ready,
    input  logic                  i_l2_resp_valid,
    input  logic [ENTRY_W-1:0]    i_l2_resp_tag,
    input  logic [LINE_W-1:0]     i_l2_resp_data,
    output logic                  o_fill_valid,
    output logic [PADDR_W-1:0]    o_fill_paddr,
    output logic [LINE_W-1:0]     o_fill_data,
    input  logic                  i_fill_ready,
    output logic [ENTRY_SIZE-1:0] o_busy_vec,
    output logic                  o_spurious_resp
);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } ent_state_e;

    ent_state_e                state_r     [ENTRY_SIZE];
    ent_state_e                state_nxt_s [ENTRY_SIZE];
    logic [PADDR_W-1:0]        paddr_r     [ENTRY_SIZE];
    logic [LINE_W-1:0]         data_r      [ENTRY_SIZE];

    logic [ENTRY_W-1:0]        req_ptr_r;
    logic [ENTRY_W-1:0]        fill_ptr_r;
    logic                      req_lock_r;
    logic [ENTRY_W-1:0]        req_lock_idx_r;
    logic                      fill_lock_r;
    logic [ENTRY_W-1:0]        fill_lock_idx_r;
    logic                      spurious_r;

    logic [ENTRY_SIZE-1:0]     free_vec_s;
    logic [ENTRY_SIZE-1:0]     req_vec_s;
    logic [ENTRY_SIZE-1:0]     fill_vec_s;
    logic [ENTRY_SIZE-1:0]     match_vec_s;
    logic [ENTRY_SIZE-1:0]     resp_hit_s;
    logic                      any_free_s;
    logic                      any_match_s;
    logic [ENTRY_W-1:0]        free_idx_s;
    logic [ENTRY_W-1:0]        match_idx_s;
    logic [ENTRY_W-1:0]        req_grant_s;
    logic [ENTRY_W-1:0]        fill_grant_s;
    logic                      alloc_fire_s;
    logic                      req_hs_s;
    logic                      fill_hs_s;
    logic                      resp_spurious_s;
    logic [PADDR_W-1:0]        miss_line_s;
    logic                      unused_offset_s;

    // Lowest set bit index of vec (0 when vec is empty).
    function automatic logic [ENTRY_W-1:0] lowest_idx(input logic [ENTRY_SIZE-1:0] vec);
        logic [ENTRY_W-1:0] pick;
        pick = '0;
        for (int k = ENTRY_SIZE - 1; k >= 0; k--) begin
            if (vec[k]) begin
                pick = ENTRY_W'(k);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // First set bit of vec at or after ptr, wrapping around.
    function automatic logic [ENTRY_W-1:0] rr_pick(input logic [ENTRY_SIZE-1:0] vec,
                                                   input logic [ENTRY_W-1:0]    ptr);
        logic [ENTRY_W-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < ENTRY_SIZE; k++) begin
            idx = (int'(ptr) + k) % ENTRY_SIZE;
            if (!found && vec[idx]) begin
                pick  = ENTRY_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Index + 1, wrapping at ENTRY_SIZE (ENTRY_SIZE need not be a power of 2).
    function automatic logic [ENTRY_W-1:0] inc_ptr(input logic [ENTRY_W-1:0] idx);
        if (idx == ENTRY_W'(ENTRY_SIZE - 1)) begin
            return '0;
        end else begin
            return idx + ENTRY_W'(1);
        end
    endfunction

    // The offset bits of the miss address play no part in scheduling.
    assign unused_offset_s = ^i_miss_paddr[LINE_OFFSET_W-1:0];
    assign miss_line_s     = {i_miss_paddr[PADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};

    // Per-entry state decode, line match against in-flight entries, response hit.
    always_comb begin
        free_vec_s  = '0;
        req_vec_s   = '0;
        fill_vec_s  = '0;
        match_vec_s = '0;
        resp_hit_s  = '0;
        for (int e = 0; e < ENTRY_SIZE; e++) begin
            free_vec_s[e]  = (state_r[e] == ST_FREE);
            req_vec_s[e]   = (state_r[e] == ST_REQ);
            fill_vec_s[e]  = (state_r[e] == ST_FILL);
            // An entry finishing its fill this cycle is still non-FREE and still matches.
            match_vec_s[e] = (state_r[e] != ST_FREE) &&
                             (paddr_r[e][PADDR_W-1:LINE_OFFSET_W] ==
                              i_miss_paddr[PADDR_W-1:LINE_OFFSET_W]);
            resp_hit_s[e]  = i_l2_resp_valid && (state_r[e] == ST_WAIT) &&
                             (i_l2_resp_tag == ENTRY_W'(e));
        end
    end

    assign any_free_s      = |free_vec_s;
    assign any_match_s     = |match_vec_s;
    assign free_idx_s      = lowest_idx(free_vec_s);
    assign match_idx_s     = lowest_idx(match_vec_s);
    assign resp_spurious_s = i_l2_resp_valid && !(|resp_hit_s);

    // Allocation is needed only when the line is new. A merge never allocates.
    assign alloc_fire_s = i_miss_valid && any_free_s && !any_match_s;

    // Miss accept and id (combinational, may depend on i_miss_paddr).
    always_comb begin
`ifdef MYOOO_MISSU_MERGE_EN
        o_miss_ready = any_match_s || any_free_s;
        if (any_match_s) begin
            o_miss_id = match_idx_s;
        end else begin
            o_miss_id = free_idx_s;
        end
`else
        o_miss_ready = !any_match_s && any_free_s;
        o_miss_id    = free_idx_s;
`endif
    end

    // L2 request: while stalled, the locked grant is kept so tag and paddr stay stable.
    always_comb begin
        o_l2_req_valid = |req_vec_s;
        if (req_lock_r) begin
            req_grant_s = req_lock_idx_r;
        end else begin
            req_grant_s = rr_pick(req_vec_s, req_ptr_r);
        end
        req_hs_s = o_l2_req_valid && i_l2_req_ready;
        if (o_l2_req_valid) begin
            o_l2_req_tag   = req_grant_s;
            o_l2_req_paddr = paddr_r[req_grant_s];
        end else begin
            o_l2_req_tag   = '0;
            o_l2_req_paddr = '0;
        end
    end

    // DCACHE fill: same grant-lock scheme as the L2 request.
    always_comb begin
        o_fill_valid = |fill_vec_s;
        if (fill_lock_r) begin
            fill_grant_s = fill_lock_idx_r;
        end else begin
            fill_grant_s = rr_pick(fill_vec_s, fill_ptr_r);
        end
        fill_hs_s = o_fill_valid && i_fill_ready;
        if (o_fill_valid) begin
            o_fill_paddr = paddr_r[fill_grant_s];
            o_fill_data  = data_r[fill_grant_s];
        end else begin
            o_fill_paddr = '0;
            o_fill_data  = '0;
        end
    end

    // Per-entry next state. Each event targets an entry in a different state, so all can happen in one cycle.
    always_comb begin
        for (int e = 0; e < ENTRY_SIZE; e++) begin
            state_nxt_s[e] = state_r[e];
            case (state_r[e])
                ST_FREE: begin
                    if (alloc_fire_s && (free_idx_s == ENTRY_W'(e))) begin
                        state_nxt_s[e] = ST_REQ;
                    end else begin
                        state_nxt_s[e] = ST_FREE;
                    end
                end
                ST_REQ: begin
                    if (req_hs_s && (req_grant_s == ENTRY_W'(e))) begin
                        state_nxt_s[e] = ST_WAIT;
                    end else begin
                        state_nxt_s[e] = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (resp_hit_s[e]) begin
                        state_nxt_s[e] = ST_FILL;
                    end else begin
                        state_nxt_s[e] = ST_WAIT;
                    end
                end
                ST_FILL: begin
                    if (fill_hs_s && (fill_grant_s == ENTRY_W'(e))) begin
                        state_nxt_s[e] = ST_FREE;
                    end else begin
                        state_nxt_s[e] = ST_FILL;
                    end
                end
                default: begin
                    state_nxt_s[e] = ST_FREE;
                end
            endcase
        end
    end

    // Entry state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int e = 0; e < ENTRY_SIZE; e++) begin
                state_r[e] <= ST_FREE;
            end
        end else begin
            for (int e = 0; e < ENTRY_SIZE; e++) begin
                state_r[e] <= state_nxt_s[e];
            end
        end
    end

    // Entry line address captured at allocation, line data captured at response.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int e = 0; e < ENTRY_SIZE; e++) begin
                paddr_r[e] <= '0;
                data_r[e]  <= '0;
            end
        end else begin
            for (int e = 0; e < ENTRY_SIZE; e++) begin
                if (alloc_fire_s && (free_idx_s == ENTRY_W'(e))) begin
                    paddr_r[e] <= miss_line_s;
                end
                if (resp_hit_s[e]) begin
                    data_r[e] <= i_l2_resp_data;
                end
            end
        end
    end

    // Round-robin pointers and grant locks for the L2 request and fill ports.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            req_ptr_r       <= '0;
            req_lock_r      <= 1'b0;
            req_lock_idx_r  <= '0;
            fill_ptr_r      <= '0;
            fill_lock_r     <= 1'b0;
            fill_lock_idx_r <= '0;
        end else begin
            if (req_hs_s) begin
                req_ptr_r  <= inc_ptr(req_grant_s);
                req_lock_r <= 1'b0;
            end else if (o_l2_req_valid) begin
                req_lock_r     <= 1'b1;
                req_lock_idx_r <= req_grant_s;
            end else begin
                req_lock_r <= 1'b0;
            end
            if (fill_hs_s) begin
                fill_ptr_r  <= inc_ptr(fill_grant_s);
                fill_lock_r <= 1'b0;
            end else if (o_fill_valid) begin
                fill_lock_r     <= 1'b1;
                fill_lock_idx_r <= fill_grant_s;
            end else begin
                fill_lock_r <= 1'b0;
            end
        end
    end

    // Spurious-response pulse, registered so it appears the cycle after the dropped response.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            spurious_r <= 1'b0;
        end else begin
            spurious_r <= resp_spurious_s;
        end
    end

    assign o_spurious_resp = spurious_r;

    // Busy vector is the complement of the FREE decode.
    assign o_busy_vec = ~free_vec_s;

endmodule
